ccip_avmm_mmio_bridge: RTL

Parametrised MMIO-to-Avalon-MM bridge for the ccip_avmm family. It accepts decoded MMIO commands (read/write, 32/64-bit, byte address, write data, CCI-P tid) and issues them as Avalon-MM master transactions. It tracks outstanding reads in order and returns tid-tagged 64-bit responses. Beyond the fixed-width command struct, it adds configurable address width, read-outstanding depth and a read-timeout recovery path. It sits between the CCI-P MMIO decoder and the AFU CSR interconnect.

---
 rtl/ccip_avmm_mmio_bridge.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ccip_avmm_mmio_bridge.sv
// MMIO command to Avalon-MM master bridge: one-slot command hold register, in-order
// read tracking FIFO, tid-tagged responses and head-of-line read timeout recovery.
module ccip_avmm_mmio_bridge #(
   parameter int ADDR_WIDTH         = 18,
   parameter int TID_WIDTH          = 9,
   parameter int MAX_RD_OUTSTANDING = 4,
   parameter int RD_TIMEOUT_CYCLES  = 512
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_is_read_i,
   input  logic                  cmd_is_32bit_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [63:0]           cmd_wdata_i,
   input  logic [TID_WIDTH-1:0]  cmd_tid_i,
   output logic [ADDR_WIDTH-1:0] avm_address_o,
   output logic                  avm_read_o,
   output logic                  avm_write_o,
   output logic [63:0]           avm_writedata_o,
   output logic [7:0]            avm_byteenable_o,
   input  logic                  avm_waitrequest_i,
   input  logic [63:0]           avm_readdata_i,
   input  logic                  avm_readdatavalid_i,
   output logic                  rsp_valid_o,
   output logic [TID_WIDTH-1:0]  rsp_tid_o,
   output logic [63:0]           rsp_data_o,
   input  logic                  err_clear_i,
   output logic                  err_timeout_o
);

   localparam int PW = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_RD_OUTSTANDING + 1);
   localparam int TW = (RD_TIMEOUT_CYCLES > 1) ? $clog2(RD_TIMEOUT_CYCLES) : 1;
   localparam int EW = TID_WIDTH + 2;
   localparam logic [TW-1:0] TO_LAST = TW'((RD_TIMEOUT_CYCLES > 0) ? RD_TIMEOUT_CYCLES - 1 : 0);
   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_RD_OUTSTANDING - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_RD_OUTSTANDING);

   logic                  avm_read_q, avm_read_d;
   logic                  avm_write_q, avm_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [63:0]           wdata_q, wdata_d;
   logic [7:0]            be_q, be_d;

   logic [EW-1:0]         fifo_q [MAX_RD_OUTSTANDING];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         rd_count_q, rd_count_d;
   logic [7:0]            drop_q, drop_d;
   logic [TW-1:0]         to_cnt_q, to_cnt_d;

   logic                  rsp_valid_q, rsp_valid_d;
   logic [TID_WIDTH-1:0]  rsp_tid_q, rsp_tid_d;
   logic [63:0]           rsp_data_q, rsp_data_d;
   logic                  err_q, err_d;

   logic                  accept, push, fifo_empty, rdv_pop, drop_dec, to_fire, pop;
   logic [EW-1:0]         head;
   logic                  head_is32, head_a2;
   logic [TID_WIDTH-1:0]  head_tid;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^cmd_addr_i[1:0];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // The hold slot frees up in the same cycle the slave takes the current command.
   assign cmd_ready_o = (!(avm_read_q || avm_write_q) || !avm_waitrequest_i) &&
                        (rd_count_q < CNT_MAX);
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign push        = accept && cmd_is_read_i;
   assign fifo_empty  = (rd_count_q == '0);
   assign head        = fifo_q[rd_ptr_q];
   assign head_tid    = head[EW-1:2];
   assign head_is32   = head[1];
   assign head_a2     = head[0];
   assign drop_dec    = avm_readdatavalid_i && (drop_q != 8'd0);
   assign rdv_pop     = avm_readdatavalid_i && (drop_q == 8'd0) && !fifo_empty;
   assign to_fire     = (RD_TIMEOUT_CYCLES > 0) && !fifo_empty &&
                        (to_cnt_q == TO_LAST) && !avm_readdatavalid_i;
   assign pop         = rdv_pop || to_fire;

   always_comb begin
      avm_read_d  = avm_read_q;
      avm_write_d = avm_write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      if (!avm_waitrequest_i) begin
         avm_read_d  = 1'b0;
         avm_write_d = 1'b0;
      end
      if (accept) begin
         avm_read_d  = cmd_is_read_i;
         avm_write_d = !cmd_is_read_i;
         addr_d      = {cmd_addr_i[ADDR_WIDTH-1:3], 3'b000};
         if (cmd_is_32bit_i) begin
            wdata_d = {cmd_wdata_i[31:0], cmd_wdata_i[31:0]};
            be_d    = cmd_addr_i[2] ? 8'hF0 : 8'h0F;
         end else begin
            wdata_d = cmd_wdata_i;
            be_d    = 8'hFF;
         end
      end
   end

   always_comb begin
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      rd_count_d = rd_count_q;
      if (push && !pop)      rd_count_d = rd_count_q + CW'(1);
      else if (pop && !push) rd_count_d = rd_count_q - CW'(1);

      drop_d = drop_q;
      if (to_fire && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      else if (drop_dec)                drop_d = drop_q - 8'd1;

      to_cnt_d = to_cnt_q;
      if (fifo_empty || pop)        to_cnt_d = '0;
      else if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + TW'(1);

      rsp_valid_d = pop;
      rsp_tid_d   = rsp_tid_q;
      rsp_data_d  = rsp_data_q;
      if (pop) begin
         rsp_tid_d = head_tid;
         if (to_fire)        rsp_data_d = 64'hFFFF_FFFF_FFFF_FFFF;
         else if (head_is32) rsp_data_d = {32'h0, head_a2 ? avm_readdata_i[63:32] : avm_readdata_i[31:0]};
         else                rsp_data_d = avm_readdata_i;
      end

      // A timeout in the same cycle as a clear leaves the error set.
      err_d = err_q;
      if (to_fire)          err_d = 1'b1;
      else if (err_clear_i) err_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         avm_read_q  <= 1'b0;
         avm_write_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_count_q  <= '0;
         drop_q      <= '0;
         to_cnt_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         avm_read_q  <= avm_read_d;
         avm_write_q <= avm_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_count_q  <= rd_count_d;
         drop_q      <= drop_d;
         to_cnt_q    <= to_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
      end
   end

   // Entry storage needs no reset: the occupancy count gates every read of it.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= {cmd_tid_i, cmd_is_32bit_i, cmd_addr_i[2]};
   end

   assign avm_address_o    = addr_q;
   assign avm_read_o       = avm_read_q;
   assign avm_write_o      = avm_write_q;
   assign avm_writedata_o  = wdata_q;
   assign avm_byteenable_o = be_q;
   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_tid_o        = rsp_tid_q;
   assign rsp_data_o       = rsp_data_q;
   assign err_timeout_o    = err_q;

endmodule
